// File: rtl/display_sequencer.sv
// Two-tube display page sequencer.
// Cycles pageSel through dest/curr/difference pages. Every page change blanks
// the tubes for BLANK ticks, then shows the page for DWELL ticks while
// multiplexing the shared segment bus between the two tubes every SCAN_DIV
// ticks. nextPage forces an immediate advance; hold freezes auto-advance.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   tick               - one-cycle timebase strobe; all intervals count ticks
//   nextPage           - one-cycle request for an immediate page advance
//   hold               - level, freezes the dwell counter
//   tube0In / tube1In  - low / high digit segment bytes for the current page
//   pageSel            - page select to the value mux (0 dest, 1 curr, 2 diff)
//   seg                - shared segment bus, 8'hFF = all off
//   digitEn            - one-hot tube enable, 2'b00 = blank
//   pageValid          - high while a page is being shown
module display_sequencer #(
  parameter int unsigned DWELL    = 2000,
  parameter int unsigned BLANK    = 50,
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       nextPage,
  input  logic       hold,
  input  logic [7:0] tube0In,
  input  logic [7:0] tube1In,
  output logic [1:0] pageSel,
  output logic [7:0] seg,
  output logic [1:0] digitEn,
  output logic       pageValid
);

  localparam int unsigned DWELL_W = 16;
  localparam int unsigned BLANK_W = 8;
  localparam int unsigned SCAN_W  = 8;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned PAGE_W  = 2;

  localparam logic [SEG_W-1:0]  SEG_OFF   = 8'hFF;
  localparam logic [1:0]        DIG_NONE  = 2'b00;
  localparam logic [1:0]        DIG_TUBE0 = 2'b01;
  localparam logic [1:0]        DIG_TUBE1 = 2'b10;
  localparam logic [PAGE_W-1:0] PAGE_LAST = 2'd2;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e              state_q;
  logic [PAGE_W-1:0]   page_sel_q;
  logic [SEG_W-1:0]    seg_q;
  logic [1:0]          digit_en_q;
  logic                page_valid_q;
  logic [DWELL_W-1:0]  dwell_cnt_q;
  logic [BLANK_W-1:0]  blank_cnt_q;
  logic [SCAN_W-1:0]   scan_cnt_q;

  // Counter values after one more tick, and the terminal-count flags they imply
  logic [DWELL_W-1:0]  dwell_cnt_d;
  logic [BLANK_W-1:0]  blank_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_d;
  logic [PAGE_W-1:0]   page_sel_d;
  logic [1:0]          digit_swap;
  logic [SEG_W-1:0]    seg_swap;
  logic [SEG_W-1:0]    seg_cur;
  logic                blank_done;
  logic                scan_done;
  logic                dwell_done;
  logic                advance;

  assign dwell_cnt_d = dwell_cnt_q + 16'd1;
  assign blank_cnt_d = blank_cnt_q + 8'd1;
  assign scan_cnt_d  = scan_cnt_q + 8'd1;
  assign page_sel_d  = (page_sel_q == PAGE_LAST) ? '0 : page_sel_q + 2'd1;

  assign blank_done = (blank_cnt_d == BLANK_W'(BLANK));
  assign scan_done  = (scan_cnt_d == SCAN_W'(SCAN_DIV));
  assign dwell_done = !hold && (dwell_cnt_d == DWELL_W'(DWELL));

  // Other tube after a scan step; seg follows whichever tube will be lit
  assign digit_swap = (digit_en_q == DIG_TUBE0) ? DIG_TUBE1 : DIG_TUBE0;
  assign seg_swap   = (digit_swap == DIG_TUBE0) ? tube0In : tube1In;
  assign seg_cur    = (digit_en_q == DIG_TUBE0) ? tube0In : tube1In;

  // A button press and a dwell expiry on the same edge collapse into one advance
  assign advance = nextPage || (state_q == ST_SHOW && tick && dwell_done);

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      page_sel_q   <= '0;
      seg_q        <= SEG_OFF;
      digit_en_q   <= DIG_NONE;
      page_valid_q <= 1'b0;
      dwell_cnt_q  <= '0;
      blank_cnt_q  <= '0;
      scan_cnt_q   <= '0;
    end else if (advance) begin
      state_q      <= ST_BLANK;
      page_sel_q   <= page_sel_d;
      seg_q        <= SEG_OFF;
      digit_en_q   <= DIG_NONE;
      page_valid_q <= 1'b0;
      blank_cnt_q  <= '0;
    end else if (tick) begin
      case (state_q)
        ST_BLANK: begin
          if (blank_done) begin
            state_q      <= ST_SHOW;
            blank_cnt_q  <= '0;
            dwell_cnt_q  <= '0;
            scan_cnt_q   <= '0;
            digit_en_q   <= DIG_TUBE0;
            seg_q        <= tube0In;
            page_valid_q <= 1'b1;
          end else begin
            blank_cnt_q <= blank_cnt_d;
          end
        end
        ST_SHOW: begin
          if (!hold) begin
            dwell_cnt_q <= dwell_cnt_d;
          end
          if (scan_done) begin
            scan_cnt_q <= '0;
            digit_en_q <= digit_swap;
            seg_q      <= seg_swap;
          end else begin
            scan_cnt_q <= scan_cnt_d;
            seg_q      <= seg_cur;
          end
        end
        default: state_q <= ST_BLANK;
      endcase
    end
  end

  assign pageSel   = page_sel_q;
  assign seg       = seg_q;
  assign digitEn   = digit_en_q;
  assign pageValid = page_valid_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Testbench for display_sequencer (DWELL=4, BLANK=2, SCAN_DIV=1, tick every 3 clks).
// Each vector is one tick period: the listed inputs on the first clock, then two
// idle clocks that must leave every output unchanged.
module tb_display_sequencer;

  localparam int unsigned DWELL    = 4;
  localparam int unsigned BLANK    = 2;
  localparam int unsigned SCAN_DIV = 1;

  localparam logic [7:0] SOFF = 8'hFF;
  localparam logic [7:0] T0   = 8'hC0;
  localparam logic [7:0] T1   = 8'hF9;
  localparam logic [7:0] T0B  = 8'hA4;
  localparam logic [7:0] T1B  = 8'hB0;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       nextPage;
  logic       hold;
  logic [7:0] tube0In;
  logic [7:0] tube1In;
  logic [1:0] pageSel;
  logic [7:0] seg;
  logic [1:0] digitEn;
  logic       pageValid;

  display_sequencer #(
    .DWELL    (DWELL),
    .BLANK    (BLANK),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .nextPage  (nextPage),
    .hold      (hold),
    .tube0In   (tube0In),
    .tube1In   (tube1In),
    .pageSel   (pageSel),
    .seg       (seg),
    .digitEn   (digitEn),
    .pageValid (pageValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       tk;
    logic       np;
    logic       hd;
    logic [1:0] pg;
    logic [7:0] sg;
    logic [1:0] en;
    logic       vl;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] pg;
    logic [7:0] sg;
    logic [1:0] en;
    logic       vl;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mkv(input string n, input logic r, input logic tk,
                               input logic np, input logic hd, input logic [1:0] pg,
                               input logic [7:0] sg, input logic [1:0] en,
                               input logic vl);
    vec_t v;
    v.name = n; v.rst = r; v.tk = tk; v.np = np; v.hd = hd;
    v.pg = pg; v.sg = sg; v.en = en; v.vl = vl;
    return v;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, exp);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    chk(e.name, "pageSel",   8'(pageSel),   8'(e.pg));
    chk(e.name, "seg",       seg,           e.sg);
    chk(e.name, "digitEn",   8'(digitEn),   8'(e.en));
    chk(e.name, "pageValid", 8'(pageValid), 8'(e.vl));
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.name = v.name; e.pg = v.pg; e.sg = v.sg; e.en = v.en; e.vl = v.vl;
    reset = v.rst; tick = v.tk; nextPage = v.np; hold = v.hd;
    sb_q.push_back(e);
    @(posedge clk); #1;
    sb_check();
    reset = 1'b0; tick = 1'b0; nextPage = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e.name = {v.name, "/idle"};
      sb_q.push_back(e);
      @(posedge clk); #1;
      sb_check();
    end
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) run_vec(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; nextPage = 1'b0; hold = 1'b0;
    tube0In = T0; tube1In = T1;

    // Reset, first show, and free-run through pages 0,1,2,0
    tbl.push_back(mkv("rst",     1,0,0,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("p0_b1",   0,1,0,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("p0_show", 0,1,0,0, 2'd0, T0,   2'b01, 1));
    tbl.push_back(mkv("p0_d1",   0,1,0,0, 2'd0, T1,   2'b10, 1));
    tbl.push_back(mkv("p0_d2",   0,1,0,0, 2'd0, T0,   2'b01, 1));
    tbl.push_back(mkv("p0_d3",   0,1,0,0, 2'd0, T1,   2'b10, 1));
    tbl.push_back(mkv("adv_p1",  0,1,0,0, 2'd1, SOFF, 2'b00, 0));
    tbl.push_back(mkv("p1_b1",   0,1,0,0, 2'd1, SOFF, 2'b00, 0));
    tbl.push_back(mkv("p1_show", 0,1,0,0, 2'd1, T0,   2'b01, 1));
    tbl.push_back(mkv("p1_d1",   0,1,0,0, 2'd1, T1,   2'b10, 1));
    tbl.push_back(mkv("p1_d2",   0,1,0,0, 2'd1, T0,   2'b01, 1));
    tbl.push_back(mkv("p1_d3",   0,1,0,0, 2'd1, T1,   2'b10, 1));
    tbl.push_back(mkv("adv_p2",  0,1,0,0, 2'd2, SOFF, 2'b00, 0));
    tbl.push_back(mkv("p2_b1",   0,1,0,0, 2'd2, SOFF, 2'b00, 0));
    tbl.push_back(mkv("p2_show", 0,1,0,0, 2'd2, T0,   2'b01, 1));
    tbl.push_back(mkv("p2_d1",   0,1,0,0, 2'd2, T1,   2'b10, 1));
    tbl.push_back(mkv("p2_d2",   0,1,0,0, 2'd2, T0,   2'b01, 1));
    tbl.push_back(mkv("p2_d3",   0,1,0,0, 2'd2, T1,   2'b10, 1));
    tbl.push_back(mkv("wrap_p0", 0,1,0,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("w0_b1",   0,1,0,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("w0_show", 0,1,0,0, 2'd0, T0,   2'b01, 1));
    tbl.push_back(mkv("w0_d1",   0,1,0,0, 2'd0, T1,   2'b10, 1));
    run_tbl();

    // Hold for 20 ticks with dwell at 1: page frozen, scan keeps toggling
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) run_vec(mkv("hold_even", 0,1,0,1, 2'd0, T0, 2'b01, 1));
      else            run_vec(mkv("hold_odd",  0,1,0,1, 2'd0, T1, 2'b10, 1));
    end
    // Release: dwell resumes at 2, 3, then advances on 4
    run_vec(mkv("rel_d2",  0,1,0,0, 2'd0, T0,   2'b01, 1));
    run_vec(mkv("rel_d3",  0,1,0,0, 2'd0, T1,   2'b10, 1));
    run_vec(mkv("rel_adv", 0,1,0,0, 2'd1, SOFF, 2'b00, 0));

    // nextPage on the dwell-expiry tick, nextPage during blank, nextPage under hold
    tbl.push_back(mkv("c_b1",     0,1,0,0, 2'd1, SOFF, 2'b00, 0));
    tbl.push_back(mkv("c_show",   0,1,0,0, 2'd1, T0,   2'b01, 1));
    tbl.push_back(mkv("c_d1",     0,1,0,0, 2'd1, T1,   2'b10, 1));
    tbl.push_back(mkv("c_d2",     0,1,0,0, 2'd1, T0,   2'b01, 1));
    tbl.push_back(mkv("c_d3",     0,1,0,0, 2'd1, T1,   2'b10, 1));
    tbl.push_back(mkv("c_np_dw4", 0,1,1,0, 2'd2, SOFF, 2'b00, 0));
    tbl.push_back(mkv("c_b1b",    0,1,0,0, 2'd2, SOFF, 2'b00, 0));
    tbl.push_back(mkv("c_np_blk", 0,0,1,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("c_rb1",    0,1,0,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("c_rshow",  0,1,0,0, 2'd0, T0,   2'b01, 1));
    tbl.push_back(mkv("c_np_hld", 0,0,1,1, 2'd1, SOFF, 2'b00, 0));
    run_tbl();

    // New tube bytes; reach page 2 mid-show, then reset together with nextPage and tick
    tube0In = T0B; tube1In = T1B;
    tbl.push_back(mkv("d_b1",     0,1,0,0, 2'd1, SOFF, 2'b00, 0));
    tbl.push_back(mkv("d_show",   0,1,0,0, 2'd1, T0B,  2'b01, 1));
    tbl.push_back(mkv("d_np",     0,0,1,0, 2'd2, SOFF, 2'b00, 0));
    tbl.push_back(mkv("d_p2b1",   0,1,0,0, 2'd2, SOFF, 2'b00, 0));
    tbl.push_back(mkv("d_p2show", 0,1,0,0, 2'd2, T0B,  2'b01, 1));
    tbl.push_back(mkv("d_p2d1",   0,1,0,0, 2'd2, T1B,  2'b10, 1));
    tbl.push_back(mkv("d_rst_np", 1,1,1,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("d_rb1",    0,1,0,0, 2'd0, SOFF, 2'b00, 0));
    tbl.push_back(mkv("d_rshow",  0,1,0,0, 2'd0, T0B,  2'b01, 1));
    tbl.push_back(mkv("d_rd1",    0,1,0,0, 2'd0, T1B,  2'b10, 1));
    run_tbl();

    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 Parameter DWELL, default 2000: tick count a page is shown (after blanking) before auto-advance; legal range 1..65535.
REQ-002 Parameter BLANK, default 50: tick count the display is blanked after every page change; legal range 1..255.
REQ-003 Parameter SCAN_DIV, default 1: tick count per digit before the scan moves to the other tube; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  one-cycle timebase strobe (nominal 1 kHz); all timing counts tick cycles, not clk cycles.
REQ-007 nextPage  input  1  one-cycle debounced button pulse; requests an immediate page advance.
REQ-008 hold  input  1  level; 1 freezes auto-advance.
REQ-009 tube0In  input  8  low-digit segment byte from the difference/value converter for the current page.
REQ-010 tube1In  input  8  high-digit segment byte for the current page.
REQ-011 pageSel  output  2  registered page select driven to the value mux: 0 = dest, 1 = curr, 2 = difference; value 3 never driven.
REQ-012 seg  output  8  registered segment bus shared by both tubes; 8'hFF = all segments off.
REQ-013 digitEn  output  2  registered one-hot tube enable, bit0 = tube0, bit1 = tube1; 2'b00 = no tube lit.
REQ-014 pageValid  output  1  registered; 1 while in SHOW.

Function
REQ-015 The state machine SHALL have exactly two states, BLANK and SHOW.
REQ-016 In BLANK: seg = 8'hFF, digitEn = 2'b00, pageValid = 0; blank counter increments on each tick; on the tick that brings it to BLANK, the next state is SHOW and the dwell and scan counters clear.
REQ-017 In SHOW: pageValid = 1; scan counter increments on each tick; on the tick that brings it to SCAN_DIV, it clears and digitEn toggles between 2'b01 and 2'b10.
REQ-018 The first SHOW cycle SHALL drive digitEn = 2'b01.
REQ-019 seg SHALL be registered from tube0In when the next digitEn is 2'b01, and from tube1In when the next digitEn is 2'b10, so that seg and digitEn always change on the same edge.
REQ-020 In SHOW with hold = 0, the dwell counter (16 bit) increments on each tick; on the tick that brings it to DWELL, a page advance occurs.
REQ-021 In SHOW with hold = 1, the dwell counter holds its value; scanning continues.
REQ-022 A page advance SHALL perform all of the following on one edge: pageSel increments (2 wraps to 0), state goes to BLANK, the blank counter clears, digitEn = 2'b00, seg = 8'hFF.
REQ-023 nextPage = 1 in either state SHALL cause a page advance regardless of hold.
REQ-024 When nextPage and a dwell-expiry tick coincide, exactly one advance SHALL occur.
REQ-025 nextPage during BLANK SHALL advance pageSel and restart the blank interval from 0.
REQ-026 Counters SHALL NOT advance on cycles with tick = 0; no output changes except via nextPage, reset or a tick.
REQ-027 Latency from the nextPage cycle to the pageSel change SHALL be exactly one clk edge.

Reset
REQ-028 When reset = 1 on a rising edge: pageSel = 0, state = BLANK, all counters = 0, seg = 8'hFF, digitEn = 2'b00, pageValid = 0.
REQ-029 Reset SHALL take priority over nextPage and tick in the same cycle.
REQ-030 Reset asserted mid-SHOW or mid-BLANK SHALL abandon the interval with no residual count.
REQ-031 After reset deasserts, the sequence SHALL restart with a full BLANK interval on page 0.

Verification (bench uses DWELL=4, BLANK=2, SCAN_DIV=1, tick every 3 clks)
REQ-032 Reset, then 2 ticks -> pageValid rises and digitEn = 01 with seg = tube0In (e.g. 8'hC0); the next tick gives digitEn = 10 with seg = tube1In (e.g. 8'hF9).
REQ-033 Free-run with hold = 0 -> pageSel sequence 0, 1, 2, 0; each page shows 4 SHOW ticks after 2 BLANK ticks.
REQ-034 hold = 1 for 20 ticks in SHOW -> pageSel stays constant and digitEn keeps toggling every tick; after hold is released, the advance occurs after the remaining dwell ticks.
REQ-035 nextPage coincident with the 4th dwell tick -> pageSel advances by exactly 1 and state becomes BLANK; nextPage during BLANK -> pageSel advances again and the blank restarts.
REQ-036 Reset asserted together with nextPage on page 2 mid-SHOW -> next cycle pageSel = 0, seg = 8'hFF, digitEn = 00, pageValid = 0.
